sram_cycle_master: RTL and testbench

//  Initiator side of the NORA external memory bus: turns one request from an internal

---
 rtl/sram_cycle_master.sv | 187 ++++++++++++++++++
 tb/tb_sram_cycle_master.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_cycle_master.sv
// Initiator for the NORA external memory bus: one request becomes a timed SRAM cycle (CS/addr setup, strobe, hold).
// Optional SRAM_CYC_STATS_EN macro adds read/write completion counters (stat_rd_o/stat_wr_o).
module sram_cycle_master #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic        clk6x,
  input  logic        resetn,
  input  logic        req_i,
  input  logic        rwn_i,
  input  logic [20:0] addr_i,
  input  logic [7:0]  wdata_i,
  output logic        ack_o,
  output logic [7:0]  rdata_o,
  output logic        busy_o,
  output logic [8:0]  MAH_o,
  output logic [11:0] MAL_o,
  output logic        MAL_oe,
  input  logic [7:0]  MD_i,
  output logic [7:0]  MD_o,
  output logic        MD_oe,
  output logic        M1CSn,
  output logic        MRDn,
  output logic        MWRn
`ifdef SRAM_CYC_STATS_EN
  ,
  output logic [15:0] stat_rd_o,
  output logic [15:0] stat_wr_o
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Counters hold "cycles remaining minus one" in the current phase.
  localparam logic [2:0] SETUP_LD  = 3'(SETUP_CYC - 1);
  localparam logic [2:0] STROBE_LD = 3'(STROBE_CYC - 1);
  localparam logic [2:0] HOLD_LD   = (HOLD_CYC == 0) ? 3'd0 : 3'(HOLD_CYC - 1);
  localparam bit         HAS_HOLD  = (HOLD_CYC != 0);

  state_t      state, state_nx;
  logic [2:0]  cnt, cnt_nx;
  logic        rwn_q, rwn_nx;
  logic        cs_n_nx, rd_n_nx, wr_n_nx;
  logic        mal_oe_nx, md_oe_nx, ack_nx;
  logic [7:0]  rdata_nx, md_nx;
  logic [8:0]  mah_nx;
  logic [11:0] mal_nx;

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    rwn_nx    = rwn_q;
    cs_n_nx   = M1CSn;
    rd_n_nx   = MRDn;
    wr_n_nx   = MWRn;
    mal_oe_nx = MAL_oe;
    md_oe_nx  = MD_oe;
    ack_nx    = 1'b0;
    rdata_nx  = rdata_o;
    md_nx     = MD_o;
    mah_nx    = MAH_o;
    mal_nx    = MAL_o;

    case (state)
      IDLE: begin
        // A request still high during the ack cycle belongs to the finished access.
        if (req_i && !ack_o) begin
          state_nx  = SETUP;
          cnt_nx    = SETUP_LD;
          rwn_nx    = rwn_i;
          mah_nx    = addr_i[20:12];
          mal_nx    = addr_i[11:0];
          md_nx     = wdata_i;
          mal_oe_nx = 1'b1;
          md_oe_nx  = ~rwn_i;
          cs_n_nx   = 1'b0;
        end
      end

      SETUP: begin
        if (cnt == 3'd0) begin
          state_nx = STROBE;
          cnt_nx   = STROBE_LD;
          rd_n_nx  = ~rwn_q;
          wr_n_nx  = rwn_q;
        end else begin
          cnt_nx = cnt - 3'd1;
        end
      end

      STROBE: begin
        if (cnt == 3'd0) begin
          rd_n_nx = 1'b1;
          wr_n_nx = 1'b1;
          if (rwn_q) begin
            rdata_nx = MD_i;
          end
          if (HAS_HOLD) begin
            state_nx = HOLD;
            cnt_nx   = HOLD_LD;
          end else begin
            state_nx  = IDLE;
            cs_n_nx   = 1'b1;
            mal_oe_nx = 1'b0;
            md_oe_nx  = 1'b0;
            ack_nx    = 1'b1;
          end
        end else begin
          cnt_nx = cnt - 3'd1;
        end
      end

      HOLD: begin
        if (cnt == 3'd0) begin
          state_nx  = IDLE;
          cs_n_nx   = 1'b1;
          mal_oe_nx = 1'b0;
          md_oe_nx  = 1'b0;
          ack_nx    = 1'b1;
        end else begin
          cnt_nx = cnt - 3'd1;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      rwn_q   <= 1'b1;
      M1CSn   <= 1'b1;
      MRDn    <= 1'b1;
      MWRn    <= 1'b1;
      MAL_oe  <= 1'b0;
      MD_oe   <= 1'b0;
      ack_o   <= 1'b0;
      rdata_o <= 8'h00;
      MD_o    <= 8'h00;
      MAH_o   <= 9'h000;
      MAL_o   <= 12'h000;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      rwn_q   <= rwn_nx;
      M1CSn   <= cs_n_nx;
      MRDn    <= rd_n_nx;
      MWRn    <= wr_n_nx;
      MAL_oe  <= mal_oe_nx;
      MD_oe   <= md_oe_nx;
      ack_o   <= ack_nx;
      rdata_o <= rdata_nx;
      MD_o    <= md_nx;
      MAH_o   <= mah_nx;
      MAL_o   <= mal_nx;
    end
  end

  assign busy_o = (state != IDLE);

`ifdef SRAM_CYC_STATS_EN
  // rwn_q cannot change while ack_o is high, so it still names the finished access.
  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      stat_rd_o <= 16'h0000;
      stat_wr_o <= 16'h0000;
    end else if (ack_o) begin
      if (rwn_q) begin
        stat_rd_o <= stat_rd_o + 16'd1;
      end else begin
        stat_wr_o <= stat_wr_o + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sram_cycle_master.sv
// Directed bench for sram_cycle_master: default-timing instance on an SRAM model plus a 3/4/0 timing instance.
module tb_sram_cycle_master;

  logic        clk6x;
  logic        resetn;
  logic        rst2_n;

  logic        req_i, rwn_i;
  logic [20:0] addr_i;
  logic [7:0]  wdata_i;
  logic        ack_o, busy_o, MAL_oe, MD_oe, M1CSn, MRDn, MWRn;
  logic [7:0]  rdata_o, md_in, MD_o;
  logic [8:0]  MAH_o;
  logic [11:0] MAL_o;

  logic        req2, rwn2;
  logic [20:0] addr2;
  logic [7:0]  wdata2;
  logic        ack2, busy2, mal_oe2, md_oe2, cs2_n, rd2_n, wr2_n;
  logic [7:0]  rdata2, md_in2, md_o2;
  logic [8:0]  mah2;
  logic [11:0] mal2;

`ifdef SRAM_CYC_STATS_EN
  logic [15:0] stat_rd, stat_wr, stat_rd2, stat_wr2;
`endif

  int errors = 0;
  int checks = 0;

  logic [7:0]  mem [0:4095];
  logic [20:0] last_wr_addr;

  sram_cycle_master dut (
    .clk6x(clk6x), .resetn(resetn), .req_i(req_i), .rwn_i(rwn_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .ack_o(ack_o), .rdata_o(rdata_o), .busy_o(busy_o), .MAH_o(MAH_o),
    .MAL_o(MAL_o), .MAL_oe(MAL_oe), .MD_i(md_in), .MD_o(MD_o), .MD_oe(MD_oe),
    .M1CSn(M1CSn), .MRDn(MRDn), .MWRn(MWRn)
`ifdef SRAM_CYC_STATS_EN
    , .stat_rd_o(stat_rd), .stat_wr_o(stat_wr)
`endif
  );

  sram_cycle_master #(.SETUP_CYC(3), .STROBE_CYC(4), .HOLD_CYC(0)) dut2 (
    .clk6x(clk6x), .resetn(rst2_n), .req_i(req2), .rwn_i(rwn2), .addr_i(addr2),
    .wdata_i(wdata2), .ack_o(ack2), .rdata_o(rdata2), .busy_o(busy2), .MAH_o(mah2),
    .MAL_o(mal2), .MAL_oe(mal_oe2), .MD_i(md_in2), .MD_o(md_o2), .MD_oe(md_oe2),
    .M1CSn(cs2_n), .MRDn(rd2_n), .MWRn(wr2_n)
`ifdef SRAM_CYC_STATS_EN
    , .stat_rd_o(stat_rd2), .stat_wr_o(stat_wr2)
`endif
  );

  initial clk6x = 1'b0;
  always #5 clk6x = ~clk6x;

  // SRAM model: combinational read while selected and strobed, write on MWRn rise.
  assign md_in  = (M1CSn === 1'b0 && MRDn === 1'b0) ? mem[MAL_o] : 8'h00;
  assign md_in2 = (cs2_n === 1'b0 && rd2_n === 1'b0) ? (mal2[7:0] ^ 8'h5A) : 8'h00;

  always @(posedge MWRn) begin
    if (M1CSn === 1'b0 && MD_oe === 1'b1) begin
      mem[MAL_o]   = MD_o;
      last_wr_addr = {MAH_o, MAL_o};
    end
  end

  always @(negedge clk6x) begin
    if (resetn === 1'b1 && rst2_n === 1'b1) begin
      checks++;
      if ((MRDn === 1'b0 && MWRn === 1'b0) || ((MRDn === 1'b0 || MWRn === 1'b0) && M1CSn !== 1'b0) ||
          (rd2_n === 1'b0 && wr2_n === 1'b0) || ((rd2_n === 1'b0 || wr2_n === 1'b0) && cs2_n !== 1'b0)) begin
        errors++;
        $display("FAIL strobe_protocol t=%0t cs/rd/wr=%b%b%b cs2/rd2/wr2=%b%b%b required no overlap, no strobe without CS",
                 $time, M1CSn, MRDn, MWRn, cs2_n, rd2_n, wr2_n);
      end
    end
  end

  task automatic access(input logic rw, input logic [20:0] a, input logic [7:0] d, input bit scramble,
                        output int lat, output int wr_low, output int rd_low,
                        output bit addr_bad, output bit md_bad);
    logic prev_wr;
    lat = -1; wr_low = 0; rd_low = 0; addr_bad = 1'b0; md_bad = 1'b0; prev_wr = 1'b1;
    @(negedge clk6x);
    req_i = 1'b1; rwn_i = rw; addr_i = a; wdata_i = d;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk6x);
      @(negedge clk6x);
      if (scramble && n == 1) begin
        req_i = 1'b0; addr_i = ~a; wdata_i = ~d;
      end
      if (M1CSn === 1'b0 && ({MAH_o, MAL_o} !== a || MAL_oe !== 1'b1)) addr_bad = 1'b1;
      if (MWRn === 1'b0) begin
        wr_low++;
        if (MD_o !== d || MD_oe !== 1'b1) md_bad = 1'b1;
      end
      if (prev_wr === 1'b0 && MWRn === 1'b1 && (MD_o !== d || MD_oe !== 1'b1)) md_bad = 1'b1;
      prev_wr = MWRn;
      if (MRDn === 1'b0) rd_low++;
      if (ack_o === 1'b1) begin
        lat = n;
        break;
      end
    end
    req_i = 1'b0;
  endtask

  task automatic acc2(input logic rw, input logic [20:0] a, input logic [7:0] d,
                      output int lat, output int rd_low);
    lat = -1; rd_low = 0;
    @(negedge clk6x);
    req2 = 1'b1; rwn2 = rw; addr2 = a; wdata2 = d;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk6x);
      @(negedge clk6x);
      if (rd2_n === 1'b0) rd_low++;
      if (ack2 === 1'b1) begin
        lat = n;
        break;
      end
    end
    req2 = 1'b0;
  endtask

  task automatic test_reset;
    int bad;
    repeat (2) @(negedge clk6x);
    checks++;
    if ({M1CSn, MRDn, MWRn, MAL_oe, MD_oe, ack_o, busy_o} !== 7'b1110000) begin
      errors++;
      $display("FAIL reset_ctrl got=%b required=1110000", {M1CSn, MRDn, MWRn, MAL_oe, MD_oe, ack_o, busy_o});
    end
    checks++;
    if (rdata_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_rdata got=%h required=00", rdata_o);
    end
    checks++;
    if ({MAH_o, MAL_o, MD_o} !== 29'h0) begin
      errors++;
      $display("FAIL reset_pins got=%h required=0", {MAH_o, MAL_o, MD_o});
    end
    resetn = 1'b1;
    rst2_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk6x);
      if (M1CSn !== 1'b1 || MRDn !== 1'b1 || MWRn !== 1'b1 || MAL_oe !== 1'b0 || MD_oe !== 1'b0 || busy_o !== 1'b0)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_after_reset bad_cycles=%0d required=0", bad);
    end
  endtask

  task automatic test_write_read;
    int lat, wl, rl;
    bit ab, mb;
    access(1'b0, 21'h00010, 8'h12, 1'b0, lat, wl, rl, ab, mb);
    checks++;
    if (lat != 5) begin
      errors++;
      $display("FAIL write_latency got=%0d required=5", lat);
    end
    @(negedge clk6x);
    checks++;
    if (ack_o !== 1'b0) begin
      errors++;
      $display("FAIL ack_pulse_width got=%b required=0", ack_o);
    end
    checks++;
    if (mem[12'h010] !== 8'h12) begin
      errors++;
      $display("FAIL sram_written got=%h required=12", mem[12'h010]);
    end
    access(1'b1, 21'h00010, 8'h00, 1'b0, lat, wl, rl, ab, mb);
    checks++;
    if (lat != 5) begin
      errors++;
      $display("FAIL read_latency got=%0d required=5", lat);
    end
    checks++;
    if (rdata_o !== 8'h12) begin
      errors++;
      $display("FAIL read_data got=%h required=12", rdata_o);
    end
    checks++;
    if (rl != 2 || wl != 0) begin
      errors++;
      $display("FAIL read_strobes rd_low=%0d wr_low=%0d required=2,0", rl, wl);
    end
  endtask

  task automatic test_addr_map;
    int lat, wl, rl;
    bit ab, mb;
    access(1'b0, 21'h1AB013, 8'h78, 1'b1, lat, wl, rl, ab, mb);
    checks++;
    if (ab !== 1'b0) begin
      errors++;
      $display("FAIL addr_stable got_bad=%b required=0", ab);
    end
    checks++;
    if (wl != 2 || rl != 0) begin
      errors++;
      $display("FAIL write_strobe wr_low=%0d rd_low=%0d required=2,0", wl, rl);
    end
    checks++;
    if (mb !== 1'b0) begin
      errors++;
      $display("FAIL write_data_valid got_bad=%b required=0", mb);
    end
    checks++;
    if (last_wr_addr !== 21'h1AB013 || mem[12'h013] !== 8'h78) begin
      errors++;
      $display("FAIL write_target addr=%h data=%h required=1ab013,78", last_wr_addr, mem[12'h013]);
    end
    checks++;
    if (lat != 5) begin
      errors++;
      $display("FAIL latched_req_latency got=%0d required=5", lat);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] got [4];
    logic [7:0] exp_d [4];
    int idx, gap, min_gap;
    bit in_gap;
    exp_d[0] = 8'h12; exp_d[1] = 8'h34; exp_d[2] = 8'h56; exp_d[3] = 8'h78;
    for (int i = 0; i < 4; i++) begin
      mem[12'h010 + 12'(i)] = exp_d[i];
      got[i] = 8'hXX;
    end
    idx = 0; gap = 0; min_gap = 99; in_gap = 1'b0;
    @(negedge clk6x);
    req_i = 1'b1; rwn_i = 1'b1; addr_i = 21'h00010;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk6x);
      @(negedge clk6x);
      if (in_gap) begin
        if (M1CSn === 1'b1) gap++;
        else begin
          in_gap = 1'b0;
          if (gap < min_gap) min_gap = gap;
        end
      end
      if (ack_o === 1'b1) begin
        got[idx] = rdata_o;
        idx++;
        if (idx == 4) break;
        addr_i = 21'h00010 + 21'(idx);
        in_gap = 1'b1;
        gap = 1;
      end
    end
    req_i = 1'b0;
    checks++;
    if (idx != 4) begin
      errors++;
      $display("FAIL b2b_count got=%0d required=4", idx);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL b2b_data[%0d] got=%h required=%h", i, got[i], exp_d[i]);
      end
    end
    checks++;
    if (min_gap < 1 || min_gap == 99) begin
      errors++;
      $display("FAIL b2b_cs_gap got=%0d required>=1", min_gap);
    end
  endtask

  task automatic test_reset_abort;
    int lat, wl, rl, acks;
    bit ab, mb, seen;
    seen = 1'b0; acks = 0;
    @(negedge clk6x);
    req_i = 1'b1; rwn_i = 1'b0; addr_i = 21'h00030; wdata_i = 8'h99;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk6x);
      @(negedge clk6x);
      if (MWRn === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL abort_reach_strobe got=0 required=1");
    end
    resetn = 1'b0;
    req_i = 1'b0;
    #1;
    checks++;
    if ({MWRn, MRDn, M1CSn, MD_oe, MAL_oe, busy_o} !== 6'b111000) begin
      errors++;
      $display("FAIL abort_async got=%b required=111000", {MWRn, MRDn, M1CSn, MD_oe, MAL_oe, busy_o});
    end
    repeat (2) begin
      @(negedge clk6x);
      if (ack_o !== 1'b0) acks++;
    end
    resetn = 1'b1;
    repeat (4) begin
      @(negedge clk6x);
      if (ack_o !== 1'b0) acks++;
    end
    checks++;
    if (acks != 0) begin
      errors++;
      $display("FAIL abort_no_ack got=%0d required=0", acks);
    end
    access(1'b0, 21'h00020, 8'h55, 1'b0, lat, wl, rl, ab, mb);
    checks++;
    if (lat != 5 || mem[12'h020] !== 8'h55) begin
      errors++;
      $display("FAIL post_reset_write lat=%0d data=%h required=5,55", lat, mem[12'h020]);
    end
    access(1'b1, 21'h00020, 8'h00, 1'b0, lat, wl, rl, ab, mb);
    checks++;
    if (lat != 5 || rdata_o !== 8'h55) begin
      errors++;
      $display("FAIL post_reset_read lat=%0d data=%h required=5,55", lat, rdata_o);
    end
  endtask

  task automatic test_params;
    logic        op_rw [5];
    logic [20:0] op_a  [5];
    logic [7:0]  op_e  [5];
    int lat, rl;
    op_rw[0] = 1'b1; op_a[0] = 21'h3; op_e[0] = 8'h59;
    op_rw[1] = 1'b1; op_a[1] = 21'h4; op_e[1] = 8'h5E;
    op_rw[2] = 1'b0; op_a[2] = 21'h5; op_e[2] = 8'h00;
    op_rw[3] = 1'b1; op_a[3] = 21'h6; op_e[3] = 8'h5C;
    op_rw[4] = 1'b0; op_a[4] = 21'h7; op_e[4] = 8'h00;
    for (int i = 0; i < 5; i++) begin
      acc2(op_rw[i], op_a[i], 8'hC0 + 8'(i), lat, rl);
      checks++;
      if (lat != 8) begin
        errors++;
        $display("FAIL p_latency[%0d] got=%0d required=8", i, lat);
      end
      if (op_rw[i]) begin
        checks++;
        if (rl != 4 || rdata2 !== op_e[i]) begin
          errors++;
          $display("FAIL p_read[%0d] rd_low=%0d data=%h required=4,%h", i, rl, rdata2, op_e[i]);
        end
      end
    end
`ifdef SRAM_CYC_STATS_EN
    repeat (2) @(negedge clk6x);
    checks++;
    if (stat_rd2 !== 16'd3 || stat_wr2 !== 16'd2) begin
      errors++;
      $display("FAIL stats got rd=%0d wr=%0d required=3,2", stat_rd2, stat_wr2);
    end
`endif
  endtask

  initial begin
    resetn = 1'b0; rst2_n = 1'b0;
    req_i = 1'b0; rwn_i = 1'b1; addr_i = '0; wdata_i = '0;
    req2 = 1'b0; rwn2 = 1'b1; addr2 = '0; wdata2 = '0;
    last_wr_addr = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    test_reset();
    test_write_read();
    test_addr_map();
    test_back_to_back();
    test_reset_abort();
    test_params();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
